dmem_resp: RTL and testbench

Data-memory responder: the target end of the datapath's load/store interface. Accepts one request at a time over a valid/ready handshake. Performs the access against an internal word array with byte-mask writes after a fixed, parameterised latency. Returns read data or an error over a second valid/ready handshake. Replaces the zero-latency combinational data memory, so the pipeline can be exercised against realistic memory timing.

---
 rtl/dmem_pkg.sv | 25 ++
 rtl/dmem_array.sv | 40 ++++
 rtl/dmem_resp.sv | 145 ++++++++++++++
 tb/tb_dmem_resp.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// latency counter width and the address range/alignment check.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int unsigned CNT_W = 4;

  // Returns 1 when addr lies outside [base, base + 4*depth_words) or is not
  // word aligned. Widened arithmetic keeps the upper bound from wrapping.
  function automatic logic addr_fault(input logic [31:0]   addr,
                                      input logic [31:0]   base,
                                      input int unsigned   depth_words);
    logic [32:0] off;
    logic [34:0] lim;
    off = {1'b0, addr} - {1'b0, base};
    lim = 35'(depth_words) << 2;
    return off[32] || (35'(off) >= lim) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the data-memory responder.
// Ports:
//   i_clk    clock
//   i_en     access enable (asserted only on the access edge)
//   i_we     1 = byte-masked write, 0 = read into the output register
//   i_addr   word index shared by both ports
//   i_wdata  write data, lane aligned
//   i_wmask  byte-lane write enables
//   o_rdata  registered read data, updated only by an enabled read
module dmem_array #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  input  logic [3:0]    i_wmask,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (i_wmask[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: accepts one load/store at a time, performs it
// against dmem_array LATENCY cycles after accept and holds the response
// until the requester takes it.
// Ports:
//   i_clk, i_rst          clock, synchronous active-low reset
//   i_req_valid/o_req_ready  request handshake
//   i_req_addr            byte address
//   i_req_wen             1 = store, 0 = load
//   i_req_wdata/i_req_wmask  store data and byte-lane enables
//   o_resp_valid/i_resp_ready  response handshake
//   o_resp_rdata          load data, 0 for stores and faults
//   o_resp_err            access faulted (range or alignment)
module dmem_resp
  import dmem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wen,
  input  logic [31:0] i_req_wdata,
  input  logic [3:0]  i_req_wmask,
  output logic        o_resp_valid,
  input  logic        i_resp_ready,
  output logic [31:0] o_resp_rdata,
  output logic        o_resp_err
);

  localparam int unsigned      AW     = $clog2(DEPTH_WORDS);
  localparam bit               LAT1   = (LATENCY == 1);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_req_ready;
  logic             r_resp_valid;
  logic             r_rd_ok;
  logic             r_err;
  logic [31:0]      r_addr;
  logic             r_wen;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;

  logic             w_accept;
  logic             w_acc_en;
  logic [31:0]      w_acc_addr;
  logic             w_acc_wen;
  logic [31:0]      w_acc_wdata;
  logic [3:0]       w_acc_wmask;
  logic             w_fault;
  logic [31:0]      w_off;
  logic [31:0]      w_arr_rdata;

  assign w_accept = (r_state == IDLE) && i_req_valid && r_req_ready;

  // With LATENCY = 1 the access happens on the accept edge, so it must use
  // the live request rather than the latches. Reset gates the enable so a
  // transaction dropped in WAIT never writes.
  assign w_acc_en    = i_rst && (LAT1 ? w_accept : (r_state == WAIT && r_cnt == CNT_W'(1)));
  assign w_acc_addr  = LAT1 ? i_req_addr  : r_addr;
  assign w_acc_wen   = LAT1 ? i_req_wen   : r_wen;
  assign w_acc_wdata = LAT1 ? i_req_wdata : r_wdata;
  assign w_acc_wmask = LAT1 ? i_req_wmask : r_wmask;
  assign w_fault     = addr_fault(w_acc_addr, BASE_ADDR, DEPTH_WORDS);
  assign w_off       = w_acc_addr - BASE_ADDR;

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .i_clk  (i_clk),
    .i_en   (w_acc_en && !w_fault),
    .i_we   (w_acc_wen),
    .i_addr (AW'(w_off >> 2)),
    .i_wdata(w_acc_wdata),
    .i_wmask(w_acc_wmask),
    .o_rdata(w_arr_rdata)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rd_ok      <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr      <= i_req_addr;
            r_wen       <= i_req_wen;
            r_wdata     <= i_req_wdata;
            r_wmask     <= i_req_wmask;
            r_req_ready <= 1'b0;
            if (LAT1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_err        <= w_fault;
              r_rd_ok      <= !w_acc_wen && !w_fault;
            end else begin
              r_cnt   <= LAT_M1;
              r_state <= WAIT;
            end
          end else begin
            r_req_ready <= 1'b1;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_err        <= w_fault;
            r_rd_ok      <= !w_acc_wen && !w_fault;
          end
        end
        RESP: begin
          if (i_resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_err        <= 1'b0;
            r_rd_ok      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  // Read data lives in the array's output register; qualify it so stores,
  // faults and reset present zero.
  assign o_resp_rdata = (r_resp_valid && r_rd_ok) ? w_arr_rdata : '0;
  assign o_resp_err   = r_resp_valid && r_err;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  parameter int LAT = 2;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned DEPTH = 4096;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_req_addr;
  logic        i_req_wen;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_wmask;
  logic        o_resp_valid;
  logic        i_resp_ready;
  logic [31:0] o_resp_rdata;
  logic        o_resp_err;

  always #5 clk = ~clk;

  dmem_resp #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_addr  (i_req_addr),
    .i_req_wen   (i_req_wen),
    .i_req_wdata (i_req_wdata),
    .i_req_wmask (i_req_wmask),
    .o_resp_valid(o_resp_valid),
    .i_resp_ready(i_resp_ready),
    .o_resp_rdata(o_resp_rdata),
    .o_resp_err  (o_resp_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int          hold;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_mdl [int unsigned];
  int          checks = 0;
  int          errors = 0;
  int unsigned pcyc   = 0;

  always @(posedge clk) pcyc <= pcyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at t=%0t", name, act, req, $time);
    end
  endtask

  // Reference model: plain address arithmetic on a sparse word map.
  function automatic exp_t model(input logic [31:0] a, input logic w,
                                 input logic [31:0] d, input logic [3:0] m);
    exp_t        e;
    longint      aa;
    int unsigned idx;
    logic [31:0] word;
    aa = longint'(a);
    e.rdata = '0;
    e.err   = (aa < longint'(BASE)) || (aa >= longint'(BASE) + 4 * longint'(DEPTH)) || (a % 4 != 0);
    e.acc   = 0;
    e.hold  = 0;
    if (!e.err) begin
      idx = (a - BASE) / 4;
      if (w) begin
        word = mem_mdl.exists(idx) ? mem_mdl[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (m[b]) word[8*b +: 8] = d[8*b +: 8];
        mem_mdl[idx] = word;
      end else begin
        e.rdata = mem_mdl.exists(idx) ? mem_mdl[idx] : 32'hxxxx_xxxx;
      end
    end
    return e;
  endfunction

  task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] m, input int hold, input bit track);
    int   t;
    exp_t e;
    @(negedge clk);
    i_req_valid = 1'b1;
    i_req_addr  = a;
    i_req_wen   = w;
    i_req_wdata = d;
    i_req_wmask = m;
    t = 0;
    while (!o_req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!o_req_ready) begin
      chk("req_accept_timeout", 32'(o_req_ready), 32'd1);
    end else if (track) begin
      e      = model(a, w, d, m);
      e.acc  = pcyc;
      e.hold = hold;
      sb.push_back(e);
    end
    @(negedge clk);
    i_req_valid = 1'b0;
  endtask

  // Monitor: pops the scoreboard when a response appears, checks latency,
  // data and stability under backpressure, and drives i_resp_ready.
  initial begin
    exp_t cur;
    int   h;
    bit   act;
    bit   pv;
    logic pr;
    i_resp_ready = 1'b1;
    act = 0;
    pv  = 0;
    pr  = 1'b1;
    h   = 0;
    forever begin
      @(negedge clk);
      if (o_resp_valid) begin
        if (!act) begin
          if (sb.size() == 0) begin
            chk("unexpected_resp", 32'(o_resp_valid), 32'd0);
            h = 0;
          end else begin
            cur = sb.pop_front();
            act = 1;
            h   = cur.hold;
            chk("latency", pcyc - cur.acc, LAT);
          end
        end else if (h > 0) begin
          h--;
        end
        if (act) begin
          chk("resp_rdata", o_resp_rdata, cur.rdata);
          chk("resp_err", 32'(o_resp_err), 32'(cur.err));
          chk("req_ready_busy", 32'(o_req_ready), 32'd0);
        end
        pr = (h == 0);
        i_resp_ready = pr;
      end else begin
        if (pv && i_rst) begin
          chk("resp_held_until_ready", 32'(pr), 32'd1);
          chk("idle_after_resp", 32'(o_req_ready), 32'd1);
        end
        act = 0;
      end
      pv = o_resp_valid;
    end
  end

  initial begin
    int   t;
    int   sel;
    logic [31:0] a;
    i_rst       = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = BASE;
    i_req_wen   = 1'b1;
    i_req_wdata = 32'hFFFF_FFFF;
    i_req_wmask = 4'hF;

    // Reset held three cycles with a request pending.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_req_ready", 32'(o_req_ready), 32'd0);
      chk("rst_resp_valid", 32'(o_resp_valid), 32'd0);
      chk("rst_resp_rdata", o_resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(o_resp_err), 32'd0);
    end
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(o_req_ready), 32'd1);
    chk("no_accept_in_rst", 32'(o_resp_valid), 32'd0);

    // Initialise a 16-word window so later loads have known contents.
    for (int i = 0; i < 16; i++)
      do_req(BASE + 32'(4 * i), 1'b1, $urandom, 4'hF, 0, 1);

    do_req(32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 1);
    do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(32'h8000_0010, 1'b1, 32'h0000_AA00, 4'b0010, 0, 1);
    do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(32'h8000_0012, 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(32'h7FFF_FFFC, 1'b1, 32'h1111_2222, 4'hF, 0, 1);
    do_req(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(32'h8000_0014, 1'b1, 32'hCAFE_F00D, 4'h0, 0, 1);
    do_req(32'h8000_0014, 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(BASE + 32'(4 * DEPTH - 4), 1'b1, 32'h5A5A_A5A5, 4'hF, 0, 1);
    do_req(BASE + 32'(4 * DEPTH - 4), 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(BASE + 32'(4 * DEPTH), 1'b0, 32'h0, 4'h0, 0, 1);
    do_req(BASE + 32'(4 * DEPTH), 1'b1, 32'h0, 4'hF, 0, 1);
    // Backpressure: response held for five cycles.
    do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, 5, 1);

    // Reset during WAIT of a store: the old word must survive.
    if (LAT > 1) begin
      t = 0;
      while ((sb.size() != 0 || o_resp_valid) && t < 100) begin
        @(negedge clk);
        t++;
      end
      do_req(32'h8000_0010, 1'b1, 32'h1234_5678, 4'hF, 0, 0);
      i_rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_wait_resp_valid", 32'(o_resp_valid), 32'd0);
      i_rst = 1'b1;
      do_req(32'h8000_0010, 1'b0, 32'h0, 4'h0, 0, 1);
    end

    // Randomised mix of in-range, misaligned and out-of-range accesses.
    for (int n = 0; n < 80; n++) begin
      sel = int'($urandom_range(0, 9));
      case (sel)
        6:       a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        7:       a = BASE - 32'(4 * $urandom_range(1, 8));
        8:       a = BASE + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 8));
        default: a = BASE + 32'(4 * $urandom_range(0, 15));
      endcase
      do_req(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
             int'($urandom_range(0, 2)), 1);
    end

    t = 0;
    while ((sb.size() != 0 || o_resp_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || o_resp_valid)
      chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
